// File: rtl/maze_move_ctrl.sv
// -----------------------------------------------------------------------------
// maze_move_ctrl
//   Player-move sequencer for the maze game. Debounces the active-low keypad,
//   checks each requested step against the maze wall ROM, moves the player,
//   counts accepted moves in BCD and handshakes a frame redraw with the VGA
//   draw engine before accepting the next move.
//
// Ports
//   Clk          system clock
//   Rst          asynchronous active-low reset
//   i_Keyboard   keys, active low: [0]=Up [1]=Down [2]=Left [3]=Right
//   i_fDrawDone  one-cycle pulse from the draw engine: frame finished
//   o_WallAddr   maze ROM address {Y,X} of the target cell
//   i_Wall       ROM data, 1 = wall, valid one cycle after o_WallAddr changes
//   o_PosX/Y     current player cell
//   o_MoveCnt    accepted moves, 3-digit BCD, saturates at 999
//   o_fRedraw    one-cycle redraw request
//   o_fGoal      high once the exit has been reached
//   o_LED        one-hot last accepted direction; all ones at the goal
// -----------------------------------------------------------------------------
module maze_move_ctrl #(
    parameter int X_W      = 4,
    parameter int Y_W      = 4,
    parameter int START_X  = 0,
    parameter int START_Y  = 0,
    parameter int GOAL_X   = 15,
    parameter int GOAL_Y   = 15,
    parameter int DEBOUNCE = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [3:0]           i_Keyboard,
    input  logic                 i_fDrawDone,
    output logic [X_W+Y_W-1:0]   o_WallAddr,
    input  logic                 i_Wall,
    output logic [X_W-1:0]       o_PosX,
    output logic [Y_W-1:0]       o_PosY,
    output logic [11:0]          o_MoveCnt,
    output logic                 o_fRedraw,
    output logic                 o_fGoal,
    output logic [3:0]           o_LED
);

    localparam int             CNT_W   = $clog2(DEBOUNCE + 1);
    localparam logic [X_W-1:0] X_MAX   = {X_W{1'b1}};
    localparam logic [Y_W-1:0] Y_MAX   = {Y_W{1'b1}};
    localparam logic [X_W-1:0] X_START = X_W'(START_X);
    localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);
    localparam logic [X_W-1:0] X_GOAL  = X_W'(GOAL_X);
    localparam logic [Y_W-1:0] Y_GOAL  = Y_W'(GOAL_Y);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ROM_WAIT  = 3'd1,
        ST_CHECK     = 3'd2,
        ST_MOVE      = 3'd3,
        ST_DRAW_WAIT = 3'd4,
        ST_GOAL      = 3'd5
    } state_t;

    // True when exactly one (active-low) key is pressed.
    function automatic logic single_key(input logic [3:0] pat);
        logic r;
        case (pat)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // BCD increment with per-digit carry, holding at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v == 12'h999) begin
            r = v;
        end else if (v[3:0] != 4'h9) begin
            r[3:0] = v[3:0] + 4'h1;
        end else if (v[7:4] != 4'h9) begin
            r[3:0] = 4'h0;
            r[7:4] = v[7:4] + 4'h1;
        end else begin
            r[7:0]  = 8'h00;
            r[11:8] = v[11:8] + 4'h1;
        end
        return r;
    endfunction

    logic [3:0]       key_meta_r, key_sync_r, key_prev_r, key_stable_r;
    logic [CNT_W-1:0] deb_cnt_r;
    logic             armed_r;
    logic             key_event_s;
    state_t           state_r;
    logic [X_W-1:0]   tgt_x_r, tgt_x_s;
    logic [Y_W-1:0]   tgt_y_r, tgt_y_s;
    logic [3:0]       dir_r;
    logic             in_grid_s;

    // Two-flop synchroniser, stability counter and stable-pattern capture.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            key_meta_r   <= 4'b1111;
            key_sync_r   <= 4'b1111;
            key_prev_r   <= 4'b1111;
            key_stable_r <= 4'b1111;
            deb_cnt_r    <= '0;
        end else begin
            key_meta_r <= i_Keyboard;
            key_sync_r <= key_meta_r;
            key_prev_r <= key_sync_r;
            if (key_sync_r != key_prev_r) begin
                deb_cnt_r <= '0;
            end else if (deb_cnt_r != CNT_W'(DEBOUNCE)) begin
                deb_cnt_r <= deb_cnt_r + CNT_W'(1);
            end else begin
                deb_cnt_r <= deb_cnt_r;
            end
            // This cycle's match is the DEBOUNCE-th consecutive one (or later).
            if ((key_sync_r == key_prev_r) && (deb_cnt_r >= CNT_W'(DEBOUNCE - 1))) begin
                key_stable_r <= key_sync_r;
            end else begin
                key_stable_r <= key_stable_r;
            end
        end
    end

    // One move per press: the event consumes armed, a full release re-arms it.
    // Multi-key patterns neither fire nor disturb armed.
    assign key_event_s = armed_r && single_key(key_stable_r);

    // Arm/disarm tracking, independent of the FSM state so releases are never missed.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            armed_r <= 1'b1;
        end else if (key_stable_r == 4'b1111) begin
            armed_r <= 1'b1;
        end else if (key_event_s) begin
            armed_r <= 1'b0;
        end else begin
            armed_r <= armed_r;
        end
    end

    // Target cell for the current stable key, with grid-edge rejection.
    always_comb begin
        tgt_x_s   = o_PosX;
        tgt_y_s   = o_PosY;
        in_grid_s = 1'b1;
        case (key_stable_r)
            4'b1110: if (o_PosY == '0)   in_grid_s = 1'b0; else tgt_y_s = o_PosY - Y_W'(1);
            4'b1101: if (o_PosY == Y_MAX) in_grid_s = 1'b0; else tgt_y_s = o_PosY + Y_W'(1);
            4'b1011: if (o_PosX == '0)   in_grid_s = 1'b0; else tgt_x_s = o_PosX - X_W'(1);
            4'b0111: if (o_PosX == X_MAX) in_grid_s = 1'b0; else tgt_x_s = o_PosX + X_W'(1);
            default: in_grid_s = 1'b0;
        endcase
    end

    // Move sequencer with registered outputs. Position, count and redraw are
    // loaded on the CHECK->MOVE edge so o_fRedraw is high exactly while in MOVE.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r    <= ST_IDLE;
            o_PosX     <= X_START;
            o_PosY     <= Y_START;
            o_MoveCnt  <= 12'h000;
            o_WallAddr <= '0;
            o_fRedraw  <= 1'b0;
            o_fGoal    <= 1'b0;
            o_LED      <= 4'b0000;
            tgt_x_r    <= X_START;
            tgt_y_r    <= Y_START;
            dir_r      <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    o_fRedraw <= 1'b0;
                    if (key_event_s && in_grid_s) begin
                        o_WallAddr <= {tgt_y_s, tgt_x_s};
                        tgt_x_r    <= tgt_x_s;
                        tgt_y_r    <= tgt_y_s;
                        dir_r      <= ~key_stable_r;
                        state_r    <= ST_ROM_WAIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ROM_WAIT: begin
                    state_r <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (i_Wall) begin
                        state_r <= ST_IDLE;
                    end else begin
                        o_PosX    <= tgt_x_r;
                        o_PosY    <= tgt_y_r;
                        o_LED     <= dir_r;
                        o_MoveCnt <= bcd_inc(o_MoveCnt);
                        o_fRedraw <= 1'b1;
                        state_r   <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    // A draw-done pulse coincident with the request is stale.
                    o_fRedraw <= 1'b0;
                    state_r   <= ST_DRAW_WAIT;
                end
                ST_DRAW_WAIT: begin
                    o_fRedraw <= 1'b0;
                    if (!i_fDrawDone) begin
                        state_r <= ST_DRAW_WAIT;
                    end else if ((o_PosX == X_GOAL) && (o_PosY == Y_GOAL)) begin
                        o_fGoal <= 1'b1;
                        o_LED   <= 4'b1111;
                        state_r <= ST_GOAL;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GOAL: begin
                    o_fRedraw <= 1'b0;
                    o_fGoal   <= 1'b1;
                    o_LED     <= 4'b1111;
                    state_r   <= ST_GOAL;
                end
                default: begin
                    o_fRedraw <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maze_move_ctrl.sv
module tb_maze_move_ctrl;

    localparam int DEB = 4;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [3:0]  i_Keyboard;
    logic        i_fDrawDone;
    logic [7:0]  o_WallAddr;
    logic        i_Wall;
    logic [3:0]  o_PosX, o_PosY;
    logic [11:0] o_MoveCnt;
    logic        o_fRedraw, o_fGoal;
    logic [3:0]  o_LED;

    maze_move_ctrl #(.DEBOUNCE(DEB)) dut (
        .Clk(Clk), .Rst(Rst), .i_Keyboard(i_Keyboard), .i_fDrawDone(i_fDrawDone),
        .o_WallAddr(o_WallAddr), .i_Wall(i_Wall), .o_PosX(o_PosX), .o_PosY(o_PosY),
        .o_MoveCnt(o_MoveCnt), .o_fRedraw(o_fRedraw), .o_fGoal(o_fGoal), .o_LED(o_LED)
    );

    always #5 Clk = ~Clk;

    // Maze ROM model: combinational read, so data is certainly valid one cycle later.
    logic wall_mem [0:255];
    assign i_Wall = wall_mem[o_WallAddr];

    typedef struct { int x; int y; int cnt; int led; } exp_t;
    exp_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state (decimal count, plain coordinates)
    int m_x, m_y, m_cnt, m_led;
    bit m_goal;

    int draw_delay = 20;
    bit draw_busy  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int n);
        return ((n / 100) << 8) | (((n / 10) % 10) << 4) | (n % 10);
    endfunction

    function automatic void model_reset();
        m_x = 0; m_y = 0; m_cnt = 0; m_led = 0; m_goal = 1'b0;
        exp_q.delete();
    endfunction

    // Expected outcome of one clean press issued while the controller is idle.
    function automatic void model_press(input int dir);
        int tx, ty;
        bit ok;
        exp_t e;
        if (m_goal) return;
        tx = m_x; ty = m_y; ok = 1'b1;
        case (dir)
            0: if (m_y == 0)  ok = 1'b0; else ty = m_y - 1;
            1: if (m_y == 15) ok = 1'b0; else ty = m_y + 1;
            2: if (m_x == 0)  ok = 1'b0; else tx = m_x - 1;
            default: if (m_x == 15) ok = 1'b0; else tx = m_x + 1;
        endcase
        if (ok && wall_mem[ty * 16 + tx]) ok = 1'b0;
        if (ok) begin
            m_x = tx; m_y = ty;
            m_cnt = (m_cnt < 999) ? m_cnt + 1 : 999;
            m_led = 1 << dir;
            e.x = m_x; e.y = m_y; e.cnt = to_bcd(m_cnt); e.led = m_led;
            exp_q.push_back(e);
            if (m_x == 15 && m_y == 15) m_goal = 1'b1;
        end
    endfunction

    // Monitor: every redraw pulse must match the next expected move.
    initial begin
        bit   prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Rst && o_fRedraw) begin
                if (prev) check("redraw_one_cycle", 1, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_redraw", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pos_x", o_PosX, e.x);
                    check("pos_y", o_PosY, e.y);
                    check("move_cnt", o_MoveCnt, e.cnt);
                    check("led", o_LED, e.led);
                end
            end
            prev = o_fRedraw;
        end
    end

    // Draw engine model: answers each redraw with a done pulse after draw_delay cycles.
    initial begin
        i_fDrawDone = 1'b0;
        forever begin
            @(negedge Clk);
            if (Rst && o_fRedraw) begin
                draw_busy = 1'b1;
                repeat (draw_delay) @(negedge Clk);
                i_fDrawDone = 1'b1;
                @(negedge Clk);
                i_fDrawDone = 1'b0;
                draw_busy = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0 && !draw_busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        if (!ok) begin
            check("idle_timeout", 0, 1);
            exp_q.delete();
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic press(input int dir);
        wait_idle();
        model_press(dir);
        i_Keyboard = ~(4'b0001 << dir);
        repeat (14) @(negedge Clk);
        i_Keyboard = 4'b1111;
        repeat (14) @(negedge Clk);
        wait_idle();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_x"}, o_PosX, m_x);
        check({tag, "_y"}, o_PosY, m_y);
        check({tag, "_cnt"}, o_MoveCnt, to_bcd(m_cnt));
    endtask

    task automatic check_reset_vals();
        check("rst_x", o_PosX, 0);
        check("rst_y", o_PosY, 0);
        check("rst_cnt", o_MoveCnt, 0);
        check("rst_redraw", o_fRedraw, 0);
        check("rst_goal", o_fGoal, 0);
        check("rst_led", o_LED, 0);
        check("rst_addr", o_WallAddr, 0);
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        i_Keyboard = 4'b1111;
        model_reset();
        repeat (3) @(negedge Clk);
        check_reset_vals();
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        for (int i = 0; i < 256; i++) wall_mem[i] = 1'b0;
        Rst = 1'b0;
        i_Keyboard = 4'b1111;

        // 1: reset values, then idle with no keys
        do_reset();
        repeat (100) @(negedge Clk);
        check_reset_vals();

        // 2: one Down move with slow draw engine, then nine more
        draw_delay = 20;
        press(1);
        check_state("down1");
        check("down1_led", o_LED, 4'b0010);
        draw_delay = 3;
        for (int i = 0; i < 9; i++) press(1);
        check_state("down10");

        // 3: edge rejection and wall rejection
        press(2);
        check("left_edge_addr", o_WallAddr, 8'hA0);
        check_state("left_edge");
        wall_mem[10 * 16 + 1] = 1'b1;
        press(3);
        check_state("wall_right");
        wall_mem[10 * 16 + 1] = 1'b0;

        // 4: glitch shorter than the debounce window, two-key chord
        i_Keyboard = 4'b1110;
        repeat (DEB - 1) @(negedge Clk);
        i_Keyboard = 4'b1111;
        repeat (30) @(negedge Clk);
        check_state("glitch");
        i_Keyboard = 4'b1100;
        repeat (500) @(negedge Clk);
        i_Keyboard = 4'b1111;
        repeat (30) @(negedge Clk);
        check_state("chord");

        // 4: a press during DRAW_WAIT is dropped, not queued
        draw_delay = 60;
        wait_idle();
        model_press(1);
        i_Keyboard = 4'b1101;
        repeat (14) @(negedge Clk);
        i_Keyboard = 4'b1111;
        repeat (14) @(negedge Clk);
        i_Keyboard = 4'b1110;
        repeat (14) @(negedge Clk);
        i_Keyboard = 4'b1111;
        repeat (14) @(negedge Clk);
        wait_idle();
        repeat (30) @(negedge Clk);
        check_state("drawwait_press");
        draw_delay = 3;

        // Randomised walk over random walls
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 0) begin
                for (int c = 0; c < 256; c++) wall_mem[c] = ($urandom_range(0, 3) == 0);
                wall_mem[m_y * 16 + m_x] = 1'b0;
            end
            press($urandom_range(0, 3));
        end
        check_state("random");
        for (int c = 0; c < 256; c++) wall_mem[c] = 1'b0;

        // 5: walk to the exit
        do_reset();
        for (int i = 0; i < 15; i++) press(3);
        for (int i = 0; i < 15; i++) press(1);
        check_state("goal");
        check("goal_flag", o_fGoal, 1);
        check("goal_led", o_LED, 4'b1111);
        press(0);
        press(2);
        check_state("goal_absorb");
        check("goal_absorb_led", o_LED, 4'b1111);

        // 6: count saturation
        do_reset();
        for (int i = 0; i < 998; i++) press((i % 2 == 0) ? 3 : 2);
        check_state("cnt998");
        press(3);
        check_state("cnt999a");
        press(2);
        check_state("cnt999b");

        // 6: reset while in ROM_WAIT
        wait_idle();
        model_press(3);
        i_Keyboard = 4'b0111;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (o_WallAddr == 8'h01) begin
                found = 1'b1;
                break;
            end
        end
        check("rom_wait_seen", found, 1);
        Rst = 1'b0;
        i_Keyboard = 4'b1111;
        model_reset();
        #1;
        check_reset_vals();
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        repeat (40) @(negedge Clk);
        check_reset_vals();

        wait_idle();
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
